// File: rtl/regfile_wb_arbiter.sv
// rtl/regfile_wb_arbiter.sv - round-robin writeback arbiter for the register file write port with pending-write scoreboard
module regfile_wb_arbiter #(
    parameter int NUM_REQ    = 2,
    parameter int REG_ADDR_W = 5,
    parameter int VALUE_W    = 32,
    parameter int NUM_REGS   = 32
) (
    input  logic                            clock,
    input  logic                            reset_n,
    input  logic [NUM_REQ-1:0]              req_valid,
    input  logic [NUM_REQ*REG_ADDR_W-1:0]   req_rd,
    input  logic [NUM_REQ*VALUE_W-1:0]      req_data,
    output logic [NUM_REQ-1:0]              req_ready,
    output logic                            wb_we,
    output logic [REG_ADDR_W-1:0]           wb_rd,
    output logic [VALUE_W-1:0]              wb_data,
    input  logic                            issue_valid,
    input  logic [REG_ADDR_W-1:0]           issue_rd,
    output logic                            issue_ready,
    input  logic [REG_ADDR_W-1:0]           rs1,
    input  logic [REG_ADDR_W-1:0]           rs2,
    output logic                            rs1_busy,
    output logic                            rs2_busy,
    output logic [NUM_REGS-1:0]             busy_vec
);

    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic [PTR_W-1:0]      ptr;
    logic [PTR_W-1:0]      gidx;
    logic                  found;
    logic [REG_ADDR_W-1:0] g_rd;
    logic [VALUE_W-1:0]    g_data;
    logic [NUM_REGS-1:0]   busy_next;

    // Search starts at the pointer and wraps; the first valid requester wins.
    always_comb begin
        int idx;
        idx       = 0;
        req_ready = '0;
        found     = 1'b0;
        gidx      = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = (int'(ptr) + k) % NUM_REQ;
            if (!found && req_valid[idx]) begin
                req_ready[idx] = 1'b1;
                gidx           = PTR_W'(idx);
                found          = 1'b1;
            end
        end
    end

    assign g_rd   = req_rd[gidx*REG_ADDR_W +: REG_ADDR_W];
    assign g_data = req_data[gidx*VALUE_W +: VALUE_W];

    assign issue_ready = issue_valid & ((issue_rd == '0) | ~busy_vec[issue_rd]);
    assign rs1_busy    = busy_vec[rs1];
    assign rs2_busy    = busy_vec[rs2];

    // Clear is applied before set so a same-register collision leaves the bit set.
    always_comb begin
        busy_next = busy_vec;
        if (wb_we)
            busy_next[wb_rd] = 1'b0;
        if (issue_ready && (issue_rd != '0))
            busy_next[issue_rd] = 1'b1;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            ptr      <= '0;
            wb_we    <= 1'b0;
            wb_rd    <= '0;
            wb_data  <= '0;
            busy_vec <= '0;
        end else begin
            busy_vec <= busy_next;
            if (found) begin
                ptr     <= (int'(gidx) == NUM_REQ - 1) ? '0 : gidx + 1'b1;
                wb_we   <= (g_rd != '0);
                wb_rd   <= g_rd;
                wb_data <= g_data;
            end else begin
                wb_we <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// tb/tb_regfile_wb_arbiter.sv - randomized bench for regfile_wb_arbiter against a behavioural model
module tb_regfile_wb_arbiter;

    localparam int NR    = 2;
    localparam int AW    = 5;
    localparam int DW    = 32;
    localparam int NREGS = 32;

    logic               clock = 1'b0;
    logic               reset_n;
    logic [NR-1:0]      req_valid;
    logic [NR*AW-1:0]   req_rd;
    logic [NR*DW-1:0]   req_data;
    logic [NR-1:0]      req_ready;
    logic               wb_we;
    logic [AW-1:0]      wb_rd;
    logic [DW-1:0]      wb_data;
    logic               issue_valid;
    logic [AW-1:0]      issue_rd;
    logic               issue_ready;
    logic [AW-1:0]      rs1, rs2;
    logic               rs1_busy, rs2_busy;
    logic [NREGS-1:0]   busy_vec;

    always #5 clock = ~clock;

    regfile_wb_arbiter #(.NUM_REQ(NR), .REG_ADDR_W(AW), .VALUE_W(DW), .NUM_REGS(NREGS)) dut (
        .clock(clock), .reset_n(reset_n),
        .req_valid(req_valid), .req_rd(req_rd), .req_data(req_data), .req_ready(req_ready),
        .wb_we(wb_we), .wb_rd(wb_rd), .wb_data(wb_data),
        .issue_valid(issue_valid), .issue_rd(issue_rd), .issue_ready(issue_ready),
        .rs1(rs1), .rs2(rs2), .rs1_busy(rs1_busy), .rs2_busy(rs2_busy),
        .busy_vec(busy_vec)
    );

    int errors = 0;
    int checks = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Model: the last granted requester, the set of reserved registers, and the pending write.
    int              m_last;
    bit              m_busy [NREGS];
    bit              m_we;
    logic [AW-1:0]   m_rd;
    logic [DW-1:0]   m_data;

    task automatic m_reset();
        m_last = NR - 1;
        foreach (m_busy[i]) m_busy[i] = 1'b0;
        m_we   = 1'b0;
        m_rd   = '0;
        m_data = '0;
    endtask

    // Lowest valid index above the last winner, otherwise lowest valid index overall.
    function automatic int m_grant();
        for (int i = m_last + 1; i < NR; i++)
            if (req_valid[i]) return i;
        for (int i = 0; i <= m_last; i++)
            if (req_valid[i]) return i;
        return -1;
    endfunction

    task automatic cycle();
        int               g;
        bit               iacc;
        logic [NR-1:0]    exp_rdy;
        logic [NREGS-1:0] exp_bv;
        #3;
        g       = m_grant();
        exp_rdy = '0;
        if (g >= 0) exp_rdy[g] = 1'b1;
        foreach (m_busy[i]) exp_bv[i] = m_busy[i];
        iacc = issue_valid && (issue_rd == 0 || !m_busy[issue_rd]);
        chk("req_ready", req_ready, exp_rdy);
        chk("issue_ready", issue_ready, iacc);
        chk("rs1_busy", rs1_busy, m_busy[rs1]);
        chk("rs2_busy", rs2_busy, m_busy[rs2]);
        chk("wb_we", wb_we, m_we);
        chk("wb_rd", wb_rd, m_rd);
        chk("wb_data", wb_data, m_data);
        chk("busy_vec", busy_vec, exp_bv);
        @(posedge clock);
        if (m_we) m_busy[m_rd] = 1'b0;
        if (iacc && issue_rd != 0) m_busy[issue_rd] = 1'b1;
        if (g >= 0) begin
            m_last = g;
            m_rd   = req_rd[g*AW +: AW];
            m_data = req_data[g*DW +: DW];
            m_we   = (m_rd != 0);
        end else begin
            m_we = 1'b0;
        end
        #1;
    endtask

    task automatic set_req(input int i, input bit v, input logic [AW-1:0] rd, input logic [DW-1:0] d);
        req_valid[i]       = v;
        req_rd[i*AW +: AW] = rd;
        req_data[i*DW +: DW] = d;
    endtask

    initial begin
        int g;
        reset_n     = 1'b0;
        req_valid   = '0;
        req_rd      = '0;
        req_data    = '0;
        issue_valid = 1'b0;
        issue_rd    = '0;
        rs1         = '0;
        rs2         = '0;
        m_reset();
        repeat (2) @(posedge clock);
        #1;
        chk("rst_wb_we", wb_we, 0);
        chk("rst_busy_vec", busy_vec, 0);
        chk("rst_req_ready", req_ready, 0);
        chk("rst_issue_ready", issue_ready, 0);
        reset_n = 1'b1;
        cycle();

        // Single request
        set_req(0, 1, 5, 32'hDEADBEEF);
        cycle();
        set_req(0, 0, 0, 0);
        chk("single_we", wb_we, 1);
        chk("single_rd", wb_rd, 5);
        chk("single_data", wb_data, 32'hDEADBEEF);
        cycle();
        chk("single_we_drop", wb_we, 0);

        // Round robin with both requesters valid
        set_req(0, 1, 3, 32'h0000_0333);
        set_req(1, 1, 7, 32'h0000_0777);
        repeat (4) cycle();
        req_valid = '0;
        cycle();

        // Scoreboard reserve, query, writeback
        issue_valid = 1'b1; issue_rd = 9;
        cycle();
        chk("sb_busy9", busy_vec[9], 1);
        rs1 = 9;
        cycle();
        issue_valid = 1'b0;
        set_req(1, 1, 9, 32'h9999_0000);
        cycle();
        set_req(1, 0, 0, 0);
        cycle();
        chk("sb_clear9", busy_vec[9], 0);

        // x0 handling
        set_req(0, 1, 0, 32'h1234_5678);
        issue_valid = 1'b1; issue_rd = 0;
        cycle();
        set_req(0, 0, 0, 0);
        issue_valid = 1'b0;
        chk("x0_we", wb_we, 0);
        cycle();

        // Randomized traffic with small register range to provoke hazards and collisions
        for (int n = 0; n < 400; n++) begin
            for (int i = 0; i < NR; i++)
                if (!req_valid[i] && ($urandom % 3 == 0))
                    set_req(i, 1, AW'($urandom_range(0, 7)), $urandom);
            issue_valid = 1'($urandom % 2);
            issue_rd    = AW'($urandom_range(0, 7));
            rs1         = AW'($urandom_range(0, 7));
            rs2         = AW'($urandom_range(0, 7));
            g = m_grant();
            cycle();
            if (g >= 0) req_valid[g] = 1'b0;
        end
        req_valid   = '0;
        issue_valid = 1'b0;
        repeat (3) cycle();

        // Asynchronous reset while a write is in flight
        issue_valid = 1'b1; issue_rd = 4;
        cycle();
        issue_valid = 1'b0;
        set_req(0, 1, 4, 32'hCAFE_F00D);
        cycle();
        set_req(0, 0, 0, 0);
        chk("pre_rst_we", wb_we, 1);
        chk("pre_rst_busy4", busy_vec[4], 1);
        #2 reset_n = 1'b0;
        #1;
        chk("mid_rst_we", wb_we, 0);
        chk("mid_rst_busy_vec", busy_vec, 0);
        chk("mid_rst_wb_rd", wb_rd, 0);
        m_reset();
        @(posedge clock);
        #1 reset_n = 1'b1;
        set_req(0, 1, 2, 32'h0000_0002);
        set_req(1, 1, 6, 32'h0000_0006);
        #3;
        chk("post_rst_grant", req_ready, 2'b01);
        cycle();
        set_req(0, 0, 0, 0);
        cycle();
        set_req(1, 0, 0, 0);
        cycle();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
